// File: rtl/counter_share_arbiter.sv
// One up counter time-shared among N_REQ requesters under round-robin arbitration.
// Each grant counts 0..limit[winner], then a one-cycle done pulse goes to the winner.
module counter_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] limit,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [CW-1:0]       count
);

  localparam int WW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  // state | meaning: IDLE arbitrate | RUN counter owned by wsel | DONE done pulse cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic             busy_q,  busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    lim_q,   lim_d;
  logic [WW-1:0]    wsel_q,  wsel_d;
  logic [WW-1:0]    rr_q,    rr_d;

  logic             win_found;
  logic [WW-1:0]    win_idx;
  logic [WW:0]      scan_idx;
  logic [CW-1:0]    lim_sel;
  logic [WW-1:0]    rr_after;

  // first set req bit scanning upward from the pointer, wrapping at N_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_q} + (WW+1)'(k);
      if (scan_idx >= (WW+1)'(N_REQ)) begin
        scan_idx = scan_idx - (WW+1)'(N_REQ);
      end
      if (!win_found && req[scan_idx[WW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[WW-1:0];
      end
    end
  end

  always_comb begin
    lim_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == WW'(i)) begin
        lim_sel = limit[i*CW +: CW];
      end
    end
  end

  assign rr_after = (wsel_q == WW'(N_REQ-1)) ? '0 : wsel_q + WW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    lim_d   = lim_q;
    wsel_d  = wsel_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        count_d = '0;
        busy_d  = 1'b0;
        if (win_found) begin
          state_d = S_RUN;
          grant_d = ONE_HOT0 << win_idx;
          busy_d  = 1'b1;
          lim_d   = lim_sel;
          wsel_d  = win_idx;
        end
      end
      S_RUN: begin
        // terminal compare outranks a same-cycle req drop
        if (count_q == lim_q) begin
          state_d = S_DONE;
          grant_d = '0;
          done_d  = ONE_HOT0 << wsel_q;
          count_d = '0;
          busy_d  = 1'b1;
          rr_d    = rr_after;
        end else if (!req[wsel_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          count_d = '0;
          busy_d  = 1'b0;
          rr_d    = rr_after;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      lim_q   <= '0;
      wsel_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      wsel_q  <= wsel_d;
      rr_q    <= rr_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter (N_REQ=4, CW=4); outputs sampled 1ns after each rising edge.
module tb_counter_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] limit;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  count;

  int total;
  int bad;

  counter_share_arbiter #(.N_REQ(4), .CW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .limit (limit),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    limit = '0;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({grant, done, busy, count} !== 13'b0) begin
      bad++;
      $display("FAIL reset got={g%b d%b b%b c%0d} want=zero", grant, done, busy, count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({grant, done, busy, count} !== 13'b0) begin
        bad++;
        $display("FAIL idle_noreq cyc%0d got={g%b d%b b%b c%0d} want=zero", i, grant, done, busy, count);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    limit = '0;
    limit[3:0] = 4'd3;
    req = 4'b0001;
    step();
    for (int i = 0; i <= 3; i++) begin
      total++;
      if ({grant, done, busy, count} !== {4'b0001, 4'b0000, 1'b1, 4'(i)}) begin
        bad++;
        $display("FAIL single_run i%0d got={g%b d%b b%b c%0d} want={g0001 d0000 b1 c%0d}", i, grant, done, busy, count, i);
      end
      step();
    end
    total++;
    if ({grant, done, busy, count} !== {4'b0000, 4'b0001, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL single_done got={g%b d%b b%b c%0d} want={g0000 d0001 b1 c0}", grant, done, busy, count);
    end
    req = '0;
    step();
    total++;
    if ({grant, done, busy, count} !== 13'b0) begin
      bad++;
      $display("FAIL single_idle got={g%b d%b b%b c%0d} want=zero", grant, done, busy, count);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    do_reset();
    limit = 16'h1111;
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      for (int c = 0; c < 2; c++) begin
        total++;
        if ({grant, done, busy, count} !== {g, 4'b0000, 1'b1, 4'(c)}) begin
          bad++;
          $display("FAIL rr_grant k%0d c%0d got={g%b d%b b%b c%0d} want={g%b d0000 b1 c%0d}", k, c, grant, done, busy, count, g, c);
        end
        step();
      end
      total++;
      if ({grant, done, busy, count} !== {4'b0000, g, 1'b1, 4'd0}) begin
        bad++;
        $display("FAIL rr_done k%0d got={g%b d%b b%b c%0d} want={g0000 d%b b1 c0}", k, grant, done, busy, count, g);
      end
      step();
      total++;
      if ({grant, done, busy, count} !== 13'b0) begin
        bad++;
        $display("FAIL rr_gap k%0d got={g%b d%b b%b c%0d} want=zero", k, grant, done, busy, count);
      end
      step();
    end
    req = '0;
  endtask

  task automatic test_limit_bounds();
    do_reset();
    limit = '0;
    req = 4'b0100;
    step();
    total++;
    if ({grant, done, busy, count} !== {4'b0100, 4'b0000, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL lim0_grant got={g%b d%b b%b c%0d} want={g0100 d0000 b1 c0}", grant, done, busy, count);
    end
    step();
    total++;
    if ({grant, done, busy, count} !== {4'b0000, 4'b0100, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL lim0_done got={g%b d%b b%b c%0d} want={g0000 d0100 b1 c0}", grant, done, busy, count);
    end
    req = '0;
    do_reset();
    limit[15:12] = 4'd15;
    req = 4'b1000;
    step();
    for (int i = 0; i <= 15; i++) begin
      total++;
      if ({grant, done, busy, count} !== {4'b1000, 4'b0000, 1'b1, 4'(i)}) begin
        bad++;
        $display("FAIL lim15_run i%0d got={g%b d%b b%b c%0d} want={g1000 d0000 b1 c%0d}", i, grant, done, busy, count, i);
      end
      step();
    end
    total++;
    if ({grant, done, busy, count} !== {4'b0000, 4'b1000, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL lim15_done got={g%b d%b b%b c%0d} want={g0000 d1000 b1 c0}", grant, done, busy, count);
    end
    req = '0;
  endtask

  task automatic test_abandon();
    do_reset();
    limit = '0;
    limit[7:4] = 4'd9;
    req = 4'b0010;
    step();
    req = 4'b1011;
    for (int i = 0; i <= 4; i++) begin
      total++;
      if ({grant, done, busy, count} !== {4'b0010, 4'b0000, 1'b1, 4'(i)}) begin
        bad++;
        $display("FAIL abandon_run i%0d got={g%b d%b b%b c%0d} want={g0010 d0000 b1 c%0d}", i, grant, done, busy, count, i);
      end
      if (i < 4) step();
    end
    req = 4'b1001;
    step();
    total++;
    if ({grant, done, busy, count} !== 13'b0) begin
      bad++;
      $display("FAIL abandon_drop got={g%b d%b b%b c%0d} want=zero", grant, done, busy, count);
    end
    step();
    total++;
    if ({grant, done, busy, count} !== {4'b1000, 4'b0000, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL abandon_next got={g%b d%b b%b c%0d} want={g1000 d0000 b1 c0}", grant, done, busy, count);
    end
    step();
    total++;
    if ({grant, done, busy, count} !== {4'b0000, 4'b1000, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL abandon_next_done got={g%b d%b b%b c%0d} want={g0000 d1000 b1 c0}", grant, done, busy, count);
    end
    req = '0;
  endtask

  task automatic test_drop_at_terminal();
    do_reset();
    limit = '0;
    limit[7:4] = 4'd9;
    req = 4'b0010;
    step();
    for (int i = 0; i <= 9; i++) begin
      total++;
      if ({grant, count} !== {4'b0010, 4'(i)}) begin
        bad++;
        $display("FAIL term_run i%0d got={g%b c%0d} want={g0010 c%0d}", i, grant, count, i);
      end
      if (i < 9) step();
    end
    req = '0;
    step();
    total++;
    if ({grant, done, busy, count} !== {4'b0000, 4'b0010, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL term_drop_done got={g%b d%b b%b c%0d} want={g0000 d0010 b1 c0}", grant, done, busy, count);
    end
    step();
    total++;
    if ({grant, done, busy, count} !== 13'b0) begin
      bad++;
      $display("FAIL term_idle got={g%b d%b b%b c%0d} want=zero", grant, done, busy, count);
    end
  endtask

  task automatic test_limit_change();
    do_reset();
    limit = '0;
    limit[11:8] = 4'd5;
    req = 4'b0100;
    step();
    for (int i = 0; i <= 5; i++) begin
      total++;
      if ({grant, done, busy, count} !== {4'b0100, 4'b0000, 1'b1, 4'(i)}) begin
        bad++;
        $display("FAIL limchg_run i%0d got={g%b d%b b%b c%0d} want={g0100 d0000 b1 c%0d}", i, grant, done, busy, count, i);
      end
      if (i == 2) limit[11:8] = 4'd1;
      step();
    end
    total++;
    if ({grant, done, busy, count} !== {4'b0000, 4'b0100, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL limchg_done got={g%b d%b b%b c%0d} want={g0000 d0100 b1 c0}", grant, done, busy, count);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    limit = '0;
    req = 4'b0010;
    step();
    step();
    total++;
    if (done !== 4'b0010) begin
      bad++;
      $display("FAIL rstmid_pre_done got=%b want=0010", done);
    end
    req = 4'b0100;
    limit[11:8] = 4'd9;
    step();
    step();
    total++;
    if ({grant, count} !== {4'b0100, 4'd0}) begin
      bad++;
      $display("FAIL rstmid_grant got={g%b c%0d} want={g0100 c0}", grant, count);
    end
    repeat (6) step();
    total++;
    if (count !== 4'd6) begin
      bad++;
      $display("FAIL rstmid_count got=%0d want=6", count);
    end
    rst = 1'b1;
    req = 4'b0110;
    step();
    total++;
    if ({grant, done, busy, count} !== 13'b0) begin
      bad++;
      $display("FAIL rstmid_clear got={g%b d%b b%b c%0d} want=zero", grant, done, busy, count);
    end
    rst = 1'b0;
    step();
    total++;
    if ({grant, done, busy, count} !== {4'b0010, 4'b0000, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL rstmid_ptr got={g%b d%b b%b c%0d} want={g0010 d0000 b1 c0}", grant, done, busy, count);
    end
    req = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req = '0;
    limit = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_limit_bounds();
    test_abandon();
    test_drop_at_terminal();
    test_limit_change();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
